// File: rtl/fifo_rd_framer.sv
// fifo_rd_framer: reads a show-ahead FIFO through a 2-entry buffer and frames fixed-length packets.
// Build option: define FIFO_RD_FRAMER_CNT_EN to add the 16-bit completed-packet counter pkt_cnt.
module fifo_rd_framer #(
    parameter int DSIZE   = 8,
    parameter int PKT_LEN = 4
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rout,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_first,
    output logic             m_last,
    output logic             pkt_busy
`ifdef FIFO_RD_FRAMER_CNT_EN
    ,
    output logic [15:0]      pkt_cnt
`endif
);
    localparam int IW = $clog2(PKT_LEN);

    typedef enum logic {IDLE, BODY} state_t;

    state_t           state;
    logic [DSIZE-1:0] head;
    logic [DSIZE-1:0] tail;
    logic [1:0]       count;
    logic [IW-1:0]    idx;
    logic             push;
    logic             pop;

    // Reading is held off during reset so no word is popped into a buffer that is being cleared.
    assign rout     = rrst_n && !rempty && (count != 2'd2);
    assign push     = rout;
    assign pop      = m_valid && m_ready;
    assign m_valid  = (count != 2'd0);
    assign m_data   = head;
    assign m_first  = (idx == '0);
    assign m_last   = (idx == IW'(PKT_LEN - 1));
    assign pkt_busy = (state == BODY);

    // Two-entry FIFO-ordered buffer: head is the presented word, tail only fills under backpressure.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop && count == 2'd2)
                head <= tail;
            else if (push && (count == 2'd0 || (pop && count == 2'd1)))
                head <= rdata;
            if (push && !pop && count == 2'd1)
                tail <= rdata;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // Beat index and framing state advance only on accepted beats, keeping first/last stable under stall.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            idx   <= '0;
            state <= IDLE;
        end else if (pop) begin
            idx   <= m_last ? '0 : idx + IW'(1);
            state <= m_last ? IDLE : BODY;
        end
    end

`ifdef FIFO_RD_FRAMER_CNT_EN
    // Completed-packet counter, wrapping naturally at 16 bits.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n)
            pkt_cnt <= '0;
        else if (pop && m_last)
            pkt_cnt <= pkt_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_fifo_rd_framer.sv
// tb_fifo_rd_framer: directed bench for fifo_rd_framer (DSIZE=8, PKT_LEN=4) with a show-ahead FIFO model.
module tb_fifo_rd_framer;
    logic       rclk = 1'b0;
    logic       rrst_n = 1'b0;
    logic       rempty;
    logic [7:0] rdata;
    logic       rout;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic       m_first;
    logic       m_last;
    logic       pkt_busy;
`ifdef FIFO_RD_FRAMER_CNT_EN
    logic [15:0] pkt_cnt;
`endif

    logic [7:0] mem [0:63];
    int rp = 0;
    int wp = 0;
    int rout_cnt = 0;
    int checks = 0;
    int failures = 0;
    int base;

    fifo_rd_framer #(.DSIZE(8), .PKT_LEN(4)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rout(rout),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_first(m_first),
        .m_last(m_last), .pkt_busy(pkt_busy)
`ifdef FIFO_RD_FRAMER_CNT_EN
        , .pkt_cnt(pkt_cnt)
`endif
    );

    always #5 rclk = ~rclk;

    assign rempty = (rp == wp);
    assign rdata  = mem[rp];

    // FIFO model: pops on rout, and counts the pops seen.
    always @(posedge rclk) begin
        if (rout) begin
            rp <= rp + 1;
            rout_cnt <= rout_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wp] = d;
        wp++;
    endtask

    initial begin
        // Reset with words already waiting in the FIFO.
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        @(negedge rclk);
        check("rst_valid", 32'(m_valid), 0);
        check("rst_rout", 32'(rout), 0);
        check("rst_first", 32'(m_first), 1);
        check("rst_last", 32'(m_last), 0);
        check("rst_busy", 32'(pkt_busy), 0);
        check("rst_data", 32'(m_data), 0);
        @(negedge rclk);
        rrst_n = 1'b1;

        // Streaming: 0x10..0x17 on consecutive cycles.
        for (int i = 0; i < 8; i++) begin
            @(negedge rclk);
            check("stream_valid", 32'(m_valid), 1);
            check("stream_data", 32'(m_data), 32'h10 + 32'(i));
            check("stream_first", 32'(m_first), 32'(i % 4 == 0));
            check("stream_last", 32'(m_last), 32'(i % 4 == 3));
        end
        @(negedge rclk);
        check("stream_drain", 32'(m_valid), 0);
        check("stream_rout_cnt", 32'(rout_cnt), 8);
        check("stream_busy", 32'(pkt_busy), 0);

        // Backpressure: 5 words, only 2 pops while m_ready=0.
        m_ready = 1'b0;
        base = rout_cnt;
        for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
        repeat (6) @(negedge rclk);
        check("bp_pops", 32'(rout_cnt - base), 2);
        check("bp_rout", 32'(rout), 0);
        check("bp_data", 32'(m_data), 32'h10);
        check("bp_first", 32'(m_first), 1);
        @(negedge rclk);
        check("bp_data_stable", 32'(m_data), 32'h10);
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_rel_valid", 32'(m_valid), 1);
            check("bp_rel_data", 32'(m_data), 32'h10 + 32'(i));
            check("bp_rel_last", 32'(m_last), 32'(i == 3));
            @(negedge rclk);
        end
        check("bp_drain", 32'(m_valid), 0);
        check("bp_busy", 32'(pkt_busy), 1);

        // Reset clears the partial packet.
        rrst_n = 1'b0;
        #1;
        check("rst2_busy", 32'(pkt_busy), 0);
        check("rst2_first", 32'(m_first), 1);
        @(negedge rclk);
        rrst_n = 1'b1;

        // Empty stall: 2 words, 20-cycle gap, then beats 3 and 4.
        push(8'h40);
        push(8'h41);
        @(negedge rclk);
        check("stall_b1", 32'(m_data), 32'h40);
        check("stall_b1_first", 32'(m_first), 1);
        @(negedge rclk);
        check("stall_b2", 32'(m_data), 32'h41);
        check("stall_b2_busy", 32'(pkt_busy), 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge rclk);
            check("stall_gap_busy", 32'(pkt_busy), 1);
            check("stall_gap_valid", 32'(m_valid), 0);
        end
        push(8'h42);
        push(8'h43);
        @(negedge rclk);
        check("stall_b3", 32'(m_data), 32'h42);
        check("stall_b3_last", 32'(m_last), 0);
        @(negedge rclk);
        check("stall_b4", 32'(m_data), 32'h43);
        check("stall_b4_last", 32'(m_last), 1);
        @(negedge rclk);
        check("stall_end_busy", 32'(pkt_busy), 0);
        check("stall_end_valid", 32'(m_valid), 0);

        // Mid-packet reset after beat 2: buffered 0x52 is discarded, 0x53 starts a new packet.
        for (int i = 0; i < 4; i++) push(8'h50 + 8'(i));
        @(negedge rclk);
        check("mrst_b1", 32'(m_data), 32'h50);
        @(negedge rclk);
        check("mrst_b2", 32'(m_data), 32'h51);
        @(negedge rclk);
        rrst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(m_valid), 0);
        check("mrst_busy", 32'(pkt_busy), 0);
        @(negedge rclk);
        rrst_n = 1'b1;
        @(negedge rclk);
        check("mrst_next_data", 32'(m_data), 32'h53);
        check("mrst_next_first", 32'(m_first), 1);
        check("mrst_next_busy", 32'(pkt_busy), 0);
        @(negedge rclk);
        check("mrst_after_busy", 32'(pkt_busy), 1);

        // Three full packets from a clean reset.
        rrst_n = 1'b0;
        @(negedge rclk);
        rrst_n = 1'b1;
        for (int i = 0; i < 12; i++) push(8'h60 + 8'(i));
        for (int i = 0; i < 12; i++) begin
            @(negedge rclk);
            check("pk3_data", 32'(m_data), 32'h60 + 32'(i));
            check("pk3_last", 32'(m_last), 32'(i % 4 == 3));
        end
        @(negedge rclk);
        check("pk3_busy", 32'(pkt_busy), 0);
`ifdef FIFO_RD_FRAMER_CNT_EN
        check("pk3_cnt", 32'(pkt_cnt), 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
